// File: rtl/demux_tree_node_pkg.sv
// Shared definitions for the snoop-side demux tree: FSM states and default widths.
package demux_tree_node_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    DROP   = 2'd2
  } node_state_t;

  localparam logic SEL_LEFT  = 1'b0;
  localparam logic SEL_RIGHT = 1'b1;

endpackage

// File: rtl/demux_tree_node_sel.sv
// Child selection for one demux node: packet-lock FSM plus round-robin pointer.
module demux_tree_node_sel
  import demux_tree_node_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic l_rdy,
  input  logic r_rdy,
  input  logic wr_en,
  input  logic done,
  output logic sel,
  output logic gate_en,
  output logic pkt_drop
);

  node_state_t state_q, state_d;
  logic        rr_q, rr_d;
  logic        sel_q, sel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      sel_q   <= SEL_LEFT;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
    end
  end

  // In IDLE the choice is made combinationally so the first beat is steered in its own cycle.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    sel_d    = sel_q;
    sel      = sel_q;
    gate_en  = 1'b0;
    pkt_drop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_en || done) begin
          if (l_rdy || r_rdy) begin
            if (l_rdy && r_rdy) begin
              sel  = rr_q;
              rr_d = ~rr_q;
            end else begin
              sel = r_rdy ? SEL_RIGHT : SEL_LEFT;
            end
            sel_d   = sel;
            gate_en = 1'b1;
            if (wr_en && !done) state_d = LOCKED;
          end else begin
            pkt_drop = 1'b1;
            if (wr_en && !done) state_d = DROP;
          end
        end
      end
      LOCKED: begin
        gate_en = 1'b1;
        if (done) state_d = IDLE;
      end
      DROP: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/demux_tree_node.sv
// Binary demux tree node: steers one packet-write stream to a locked child, registered outputs.
module demux_tree_node
  import demux_tree_node_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PESS       = 0
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  done,
  output logic                  rdy,
  output logic                  pkt_drop,
  output logic [ADDR_WIDTH-1:0] left_addr,
  output logic [DATA_WIDTH-1:0] left_wr_data,
  output logic                  left_wr_en,
  output logic                  left_done,
  input  logic                  left_rdy,
  output logic [ADDR_WIDTH-1:0] right_addr,
  output logic [DATA_WIDTH-1:0] right_wr_data,
  output logic                  right_wr_en,
  output logic                  right_done,
  input  logic                  right_rdy
);

  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_wr_en, s_done, s_lrdy, s_rrdy;

  // Child readiness is staged with the stream so selection sees a consistent snapshot.
  if (PESS != 0) begin : g_pess
    always_ff @(posedge clk) begin
      if (rst) begin
        s_addr  <= '0;
        s_data  <= '0;
        s_wr_en <= 1'b0;
        s_done  <= 1'b0;
        s_lrdy  <= 1'b0;
        s_rrdy  <= 1'b0;
      end else begin
        s_addr  <= addr;
        s_data  <= wr_data;
        s_wr_en <= wr_en;
        s_done  <= done;
        s_lrdy  <= left_rdy;
        s_rrdy  <= right_rdy;
      end
    end
  end else begin : g_direct
    always_comb begin
      s_addr  = addr;
      s_data  = wr_data;
      s_wr_en = wr_en;
      s_done  = done;
      s_lrdy  = left_rdy;
      s_rrdy  = right_rdy;
    end
  end

  logic sel, gate_en, drop;

  demux_tree_node_sel u_sel (
    .clk      (clk),
    .rst      (rst),
    .l_rdy    (s_lrdy),
    .r_rdy    (s_rrdy),
    .wr_en    (s_wr_en),
    .done     (s_done),
    .sel      (sel),
    .gate_en  (gate_en),
    .pkt_drop (drop)
  );

  logic to_left, to_right;
  always_comb begin
    to_left  = gate_en && (sel == SEL_LEFT);
    to_right = gate_en && (sel == SEL_RIGHT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy           <= 1'b0;
      pkt_drop      <= 1'b0;
      left_addr     <= '0;
      left_wr_data  <= '0;
      left_wr_en    <= 1'b0;
      left_done     <= 1'b0;
      right_addr    <= '0;
      right_wr_data <= '0;
      right_wr_en   <= 1'b0;
      right_done    <= 1'b0;
    end else begin
      rdy           <= s_lrdy | s_rrdy;
      pkt_drop      <= drop;
      left_addr     <= s_addr;
      left_wr_data  <= s_data;
      left_wr_en    <= s_wr_en & to_left;
      left_done     <= s_done & to_left;
      right_addr    <= s_addr;
      right_wr_data <= s_data;
      right_wr_en   <= s_wr_en & to_right;
      right_done    <= s_done & to_right;
    end
  end

endmodule

// File: tb/tb_demux_tree_node.sv
// Directed and randomized checks of demux_tree_node (PESS=0 and PESS=1) against a packet-level model.
module tb_demux_tree_node;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          wr_en, done, left_rdy, right_rdy;

  logic          rdy0, drop0, lwe0, ldn0, rwe0, rdn0;
  logic [AW-1:0] la0, ra0;
  logic [DW-1:0] ld0, rd0;
  logic          rdy1, drop1, lwe1, ldn1, rwe1, rdn1;
  logic [AW-1:0] la1, ra1;
  logic [DW-1:0] ld1, rd1;

  always #5 clk = ~clk;

  demux_tree_node #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PESS(0)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .wr_en(wr_en), .done(done),
    .rdy(rdy0), .pkt_drop(drop0),
    .left_addr(la0), .left_wr_data(ld0), .left_wr_en(lwe0), .left_done(ldn0), .left_rdy(left_rdy),
    .right_addr(ra0), .right_wr_data(rd0), .right_wr_en(rwe0), .right_done(rdn0), .right_rdy(right_rdy)
  );

  demux_tree_node #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PESS(1)) dut_p (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .wr_en(wr_en), .done(done),
    .rdy(rdy1), .pkt_drop(drop1),
    .left_addr(la1), .left_wr_data(ld1), .left_wr_en(lwe1), .left_done(ldn1), .left_rdy(left_rdy),
    .right_addr(ra1), .right_wr_data(rd1), .right_wr_en(rwe1), .right_done(rdn1), .right_rdy(right_rdy)
  );

  typedef struct packed {
    logic rdy, drop, lwe, ldn, rwe, rdn;
  } ctrl_t;

  typedef struct packed {
    logic          we, dn, lr, rr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  // Packet-level model: per instance, whether a packet is open, where it goes (0 L, 1 R, 2 dropped)
  // and which child wins the next tie.
  int    open_pkt [2];
  int    dest     [2];
  int    next_tie [2];
  beat_t prev;
  int    checks = 0;
  int    passed = 0;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      open_pkt[m] = 0;
      dest[m]     = 0;
      next_tie[m] = 0;
    end
    prev = '0;
  endtask

  task automatic model(input int m, input beat_t b, output ctrl_t c);
    int active;
    c      = '0;
    c.rdy  = b.lr | b.rr;
    active = 0;
    if (open_pkt[m] != 0) begin
      active = 1;
      if (b.dn) open_pkt[m] = 0;
    end else if (b.we || b.dn) begin
      active = 1;
      if (b.lr && b.rr) begin
        dest[m]     = next_tie[m];
        next_tie[m] = 1 - next_tie[m];
      end else if (b.lr) dest[m] = 0;
      else if (b.rr) dest[m] = 1;
      else begin
        dest[m] = 2;
        c.drop  = 1'b1;
      end
      open_pkt[m] = (b.we && !b.dn) ? 1 : 0;
    end
    if (active != 0 && dest[m] == 0) begin c.lwe = b.we; c.ldn = b.dn; end
    if (active != 0 && dest[m] == 1) begin c.rwe = b.we; c.rdn = b.dn; end
  endtask

  task automatic check_ctrl(input string tag, input ctrl_t obs, input ctrl_t exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s ctrl{rdy,drop,lwe,ldn,rwe,rdn} observed=%b expected=%b at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_data(input string tag, input logic [2*(AW+DW)-1:0] obs, input logic [2*(AW+DW)-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s data{la,ld,ra,rd} observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step(input string tag, input logic r, input logic we, input logic dn,
                      input logic lr, input logic rr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    beat_t cur;
    ctrl_t e0, e1;
    logic [AW-1:0] ea0, ea1;
    logic [DW-1:0] ed0, ed1;
    cur       = '{we: we, dn: dn, lr: lr, rr: rr, a: a, d: d};
    rst       = r;
    wr_en     = we;
    done      = dn;
    left_rdy  = lr;
    right_rdy = rr;
    addr      = a;
    wr_data   = d;
    @(posedge clk);
    if (r) begin
      model_reset();
      e0 = '0; e1 = '0; ea0 = '0; ea1 = '0; ed0 = '0; ed1 = '0;
    end else begin
      model(0, cur, e0);
      ea0 = a; ed0 = d;
      model(1, prev, e1);
      ea1 = prev.a; ed1 = prev.d;
      prev = cur;
    end
    #1;
    check_ctrl({tag, "/p0"}, {rdy0, drop0, lwe0, ldn0, rwe0, rdn0}, e0);
    check_data({tag, "/p0"}, {la0, ld0, ra0, rd0}, {ea0, ed0, ea0, ed0});
    check_ctrl({tag, "/p1"}, {rdy1, drop1, lwe1, ldn1, rwe1, rdn1}, e1);
    check_data({tag, "/p1"}, {la1, ld1, ra1, rd1}, {ea1, ed1, ea1, ed1});
  endtask

  task automatic idle(input string tag, input logic lr, input logic rr, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, lr, rr, '0, '0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; done = 1'b0; left_rdy = 1'b0; right_rdy = 1'b0;
    addr = '0; wr_data = '0;
    model_reset();

    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'h3ff, 32'hdeadbeef);

    // Left only ready: four beats, done on the last.
    idle("left4", 1'b1, 1'b0, 2);
    for (int i = 0; i < 4; i++)
      step("left4", 1'b0, 1'b1, (i == 3), 1'b1, 1'b0, AW'(i), 32'h1000 + DW'(i));
    idle("left4", 1'b1, 1'b0, 3);

    // Both ready: three back-to-back two-beat packets alternate L, R, L.
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 2; i++)
        step("rr3", 1'b0, 1'b1, (i == 1), 1'b1, 1'b1, AW'(16 + 2*p + i), 32'h2000 + DW'(p));
    idle("rr3", 1'b1, 1'b1, 2);

    // Nobody ready: one drop pulse, no strobes; next packet goes right.
    idle("drop", 1'b0, 1'b0, 2);
    for (int i = 0; i < 3; i++)
      step("drop", 1'b0, 1'b1, (i == 2), 1'b0, 1'b0, AW'(32 + i), 32'h3000 + DW'(i));
    for (int i = 0; i < 2; i++)
      step("drop_r", 1'b0, 1'b1, (i == 1), 1'b0, 1'b1, AW'(40 + i), 32'h3100 + DW'(i));
    idle("drop_r", 1'b0, 1'b1, 2);

    // Lock held on left while readiness flips mid-packet.
    idle("lock", 1'b1, 1'b0, 1);
    step("lock", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd50, 32'h4000);
    for (int i = 1; i < 5; i++)
      step("lock", 1'b0, 1'b1, (i == 4), 1'b0, 1'b1, AW'(50 + i), 32'h4000 + DW'(i));
    idle("lock", 1'b1, 1'b1, 2);

    // Leave tie pointer on right, then reset mid-packet; next tie goes left again.
    step("rstmid", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd60, 32'h5000);
    for (int i = 0; i < 5; i++)
      step("rstmid", (i == 2), 1'b1, (i == 4), 1'b1, 1'b1, AW'(64 + i), 32'h5100 + DW'(i));
    idle("rstmid", 1'b1, 1'b1, 1);
    for (int i = 0; i < 2; i++)
      step("after_rst", 1'b0, 1'b1, (i == 1), 1'b1, 1'b1, AW'(80 + i), 32'h5200 + DW'(i));
    idle("after_rst", 1'b1, 1'b1, 2);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 60), AW'($urandom), DW'($urandom));
    idle("tail", 1'b0, 1'b0, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
